load_store_sequencer: RTL

- Multi-cycle sequencer that executes the LOAD (opcode 00101, R0 <- mem[Rx]) and STORE (opcode 00110, mem[Rx] <- R0) instructions.
- Sits beside the control unit. It drives the register-file select/enable lines and the data-memory request handshake while holding the program counter via `stall`.
- All its register and memory outputs are zero when idle, so they can be OR-merged with the control unit's single-cycle signals.

---
 rtl/load_store_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/load_store_sequencer.sv
// load_store_sequencer: multi-cycle LOAD/STORE engine.
// Outputs are zero when idle so they can be OR-merged.
module load_store_sequencer #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instValid,
  input  logic [4:0]        opcode,
  input  logic [2:0]        regField,
  input  logic [DATA_W-1:0] regData,
  input  logic [DATA_W-1:0] memRdData,
  input  logic              memAck,
  output logic [2:0]        regOutSel,
  output logic              regOutEn,
  output logic [2:0]        regInSel,
  output logic              regInEn,
  output logic [DATA_W-1:0] regInData,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWrData,
  output logic              stall,
  output logic              fault
);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, REQ, WB
  } state_e;

  localparam logic [4:0] OP_LOAD  = 5'd5;
  localparam logic [4:0] OP_STORE = 5'd6;
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              is_load_q, is_load_d;
  logic [2:0]        rx_idx_q, rx_idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              fault_q, fault_d;

  logic mem_op;
  logic to_last;

  assign mem_op  = instValid &
                   (opcode == OP_LOAD |
                    opcode == OP_STORE);
  assign to_last = (to_cnt_q == TO_LAST);
  assign fault   = fault_q;

  // Next-state and datapath register updates.
  always_comb begin
    state_d   = state_q;
    is_load_d = is_load_q;
    rx_idx_d  = rx_idx_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    rd_data_d = rd_data_q;
    to_cnt_d  = to_cnt_q;
    fault_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_op) begin
          is_load_d = (opcode == OP_LOAD);
          rx_idx_d  = regField;
          state_d   = RD_ADDR;
        end
      end
      RD_ADDR: begin
        addr_d   = regData[ADDR_W-1:0];
        to_cnt_d = '0;
        state_d  = is_load_q ? REQ : RD_DATA;
      end
      RD_DATA: begin
        wr_data_d = regData;
        to_cnt_d  = '0;
        state_d   = REQ;
      end
      REQ: begin
        if (memAck) begin
          if (is_load_q) begin
            rd_data_d = memRdData;
            state_d   = WB;
          end else begin
            state_d = IDLE;
          end
        end else if (to_last) begin
          fault_d = 1'b1;
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    regOutSel = '0;
    regOutEn  = 1'b0;
    regInSel  = '0;
    regInEn   = 1'b0;
    regInData = '0;
    memReq    = 1'b0;
    memWe     = 1'b0;
    memAddr   = '0;
    memWrData = '0;
    stall     = 1'b0;
    unique case (state_q)
      IDLE: stall = mem_op;
      RD_ADDR: begin
        regOutEn  = 1'b1;
        regOutSel = rx_idx_q;
        stall     = 1'b1;
      end
      RD_DATA: begin
        regOutEn = 1'b1;
        stall    = 1'b1;
      end
      REQ: begin
        memReq  = 1'b1;
        memAddr = addr_q;
        memWe   = ~is_load_q;
        if (!is_load_q) memWrData = wr_data_q;
        if (memAck) stall = is_load_q;
        else        stall = ~to_last;
      end
      WB: begin
        regInEn   = 1'b1;
        regInData = rd_data_q;
      end
      default: ;
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      is_load_q <= 1'b0;
      rx_idx_q  <= '0;
      addr_q    <= '0;
      wr_data_q <= '0;
      rd_data_q <= '0;
      to_cnt_q  <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
      rx_idx_q  <= rx_idx_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      rd_data_q <= rd_data_d;
      to_cnt_q  <= to_cnt_d;
      fault_q   <= fault_d;
    end
  end

endmodule
